// File: rtl/pc_fetch_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// pc_fetch_pkg
// Shared types and defaults for the program-counter / next-PC fetch stage.
//   state_e   : fetch FSM states (IDLE, RUN, HALTED)
//   pc_sel_e  : next-PC source select (SEQ, TGT, RET, HOLD, RST)
//   PC_W_DEF  : default PC / jump-target width (matches the jump LUT output)
// -----------------------------------------------------------------------------
package pc_fetch_pkg;

  localparam int PC_W_DEF      = 12;
  localparam int RAS_DEPTH_DEF = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_HALTED = 2'd2
  } state_e;

  typedef enum logic [2:0] {
    SEL_SEQ  = 3'd0,
    SEL_TGT  = 3'd1,
    SEL_RET  = 3'd2,
    SEL_HOLD = 3'd3,
    SEL_RST  = 3'd4
  } pc_sel_e;

endpackage

// File: rtl/pc_fetch_ctrl_if.sv
// -----------------------------------------------------------------------------
// pc_fetch_ctrl_if
// Control/status bundle between the decode side and the fetch controller.
//   master : drives Start/Stall/Halt/Jmp/BrEn/BrCond/Call/Ret/Target,
//            observes ProgCtr/Busy/Done/Fault
//   slave  : the fetch controller (mirror directions)
// -----------------------------------------------------------------------------
interface pc_fetch_ctrl_if
  import pc_fetch_pkg::*;
#(
  parameter int PC_W = PC_W_DEF
);

  logic            Start;
  logic            Stall;
  logic            Halt;
  logic            Jmp;
  logic            BrEn;
  logic            BrCond;
  logic            Call;
  logic            Ret;
  logic [PC_W-1:0] Target;
  logic [PC_W-1:0] ProgCtr;
  logic            Busy;
  logic            Done;
  logic            Fault;

  modport master (
    output Start, Stall, Halt, Jmp, BrEn, BrCond, Call, Ret, Target,
    input  ProgCtr, Busy, Done, Fault
  );

  modport slave (
    input  Start, Stall, Halt, Jmp, BrEn, BrCond, Call, Ret, Target,
    output ProgCtr, Busy, Done, Fault
  );

endinterface

// File: rtl/pc_fetch_ctrl_ras_stack.sv
// -----------------------------------------------------------------------------
// ras_stack
// RAS_DEPTH x PC_W return-address LIFO.
//   Clk, Reset : clock, async active-low reset (empties the stack)
//   i_push     : write i_data as new top (ignored when full)
//   i_pop      : discard top (ignored when empty)
//   i_clr      : empty the stack (highest priority)
//   o_top      : current top entry (valid when !o_empty)
//   o_full     : count == RAS_DEPTH
//   o_empty    : count == 0
// -----------------------------------------------------------------------------
module ras_stack
  import pc_fetch_pkg::*;
#(
  parameter int PC_W      = PC_W_DEF,
  parameter int RAS_DEPTH = RAS_DEPTH_DEF
) (
  input  logic            Clk,
  input  logic            Reset,
  input  logic            i_push,
  input  logic            i_pop,
  input  logic            i_clr,
  input  logic [PC_W-1:0] i_data,
  output logic [PC_W-1:0] o_top,
  output logic            o_full,
  output logic            o_empty
);

  localparam int AW = $clog2(RAS_DEPTH);
  localparam int CW = AW + 1;

  logic [PC_W-1:0] r_mem [RAS_DEPTH];
  logic [CW-1:0]   r_cnt;
  logic [AW-1:0]   w_top_idx;

  // Low bits of the count address the next free slot; when full they wrap to
  // zero, so count-1 in AW bits still lands on the real top entry.
  assign w_top_idx = r_cnt[AW-1:0] - AW'(1);
  assign o_top     = r_mem[w_top_idx];
  assign o_empty   = (r_cnt == CW'(0));
  assign o_full    = (r_cnt == CW'(RAS_DEPTH));

  // Stack storage and occupancy count.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      r_cnt <= CW'(0);
      for (int i = 0; i < RAS_DEPTH; i++) begin
        r_mem[i] <= {PC_W{1'b0}};
      end
    end else if (i_clr) begin
      r_cnt <= CW'(0);
    end else if (i_push && !o_full) begin
      r_mem[r_cnt[AW-1:0]] <= i_data;
      r_cnt                <= r_cnt + CW'(1);
    end else if (i_pop && !o_empty) begin
      r_cnt <= r_cnt - CW'(1);
    end else begin
      r_cnt <= r_cnt;
    end
  end

endmodule

// File: rtl/pc_fetch_ctrl.sv
// -----------------------------------------------------------------------------
// pc_fetch_ctrl
// Program counter and next-PC selection downstream of the jump LUT.
//   Clk   : rising-edge clock
//   Reset : async active-low reset -> IDLE, ProgCtr=RESET_PC, RAS empty
//   bus   : slave side of pc_fetch_ctrl_if
//           in : Start Stall Halt Jmp BrEn BrCond Call Ret Target
//           out: ProgCtr (fetch address), Busy (RUN), Done (HALTED),
//                Fault (sticky RAS overflow/underflow)
// All outputs come straight from flops.
// -----------------------------------------------------------------------------
module pc_fetch_ctrl
  import pc_fetch_pkg::*;
#(
  parameter int              PC_W      = PC_W_DEF,
  parameter int              RAS_DEPTH = RAS_DEPTH_DEF,
  parameter logic [PC_W-1:0] RESET_PC  = {PC_W{1'b0}}
) (
  input  logic               Clk,
  input  logic               Reset,
  pc_fetch_ctrl_if.slave     bus
);

  state_e          r_state;
  logic [PC_W-1:0] r_pc;
  logic            r_busy;
  logic            r_done;
  logic            r_fault;

  state_e          w_next_state;
  pc_sel_e         w_sel;
  logic            w_push;
  logic            w_pop;
  logic            w_clr;
  logic            w_fault_next;
  logic [PC_W-1:0] w_pc_inc;
  logic [PC_W-1:0] w_ras_top;
  logic            w_ras_full;
  logic            w_ras_empty;

  // Wraps silently at 2^PC_W; also the return address pushed on Call.
  assign w_pc_inc = r_pc + PC_W'(1);

  ras_stack #(
    .PC_W      (PC_W),
    .RAS_DEPTH (RAS_DEPTH)
  ) u_ras (
    .Clk     (Clk),
    .Reset   (Reset),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_clr   (w_clr),
    .i_data  (w_pc_inc),
    .o_top   (w_ras_top),
    .o_full  (w_ras_full),
    .o_empty (w_ras_empty)
  );

  // Per-cycle control decode: next state, PC source and RAS operation.
  always_comb begin
    w_next_state = r_state;
    w_sel        = SEL_HOLD;
    w_push       = 1'b0;
    w_pop        = 1'b0;
    w_clr        = 1'b0;
    w_fault_next = r_fault;
    case (r_state)
      ST_IDLE, ST_HALTED: begin
        if (bus.Start) begin
          w_next_state = ST_RUN;
          w_sel        = SEL_RST;
          w_clr        = 1'b1;
          w_fault_next = 1'b0;
        end else begin
          w_next_state = r_state;
        end
      end
      ST_RUN: begin
        if (bus.Start) begin
          w_next_state = ST_RUN;
          w_sel        = SEL_RST;
          w_clr        = 1'b1;
          w_fault_next = 1'b0;
        end else if (bus.Stall) begin
          w_sel = SEL_HOLD;
        end else if (bus.Halt) begin
          w_next_state = ST_HALTED;
        end else if (bus.Ret) begin
          if (w_ras_empty) begin
            w_fault_next = 1'b1;
            w_next_state = ST_HALTED;
          end else begin
            w_sel = SEL_RET;
            w_pop = 1'b1;
          end
        end else if (bus.Call) begin
          if (w_ras_full) begin
            w_fault_next = 1'b1;
            w_next_state = ST_HALTED;
          end else begin
            w_sel  = SEL_TGT;
            w_push = 1'b1;
          end
        end else if (bus.Jmp || (bus.BrEn && bus.BrCond)) begin
          w_sel = SEL_TGT;
        end else begin
          w_sel = SEL_SEQ;
        end
      end
      default: begin
        w_next_state = ST_IDLE;
        w_sel        = SEL_RST;
        w_clr        = 1'b1;
        w_fault_next = 1'b0;
      end
    endcase
  end

  // FSM state, program counter and registered status flags.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      r_state <= ST_IDLE;
      r_pc    <= RESET_PC;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_fault <= 1'b0;
    end else begin
      r_state <= w_next_state;
      r_busy  <= (w_next_state == ST_RUN);
      r_done  <= (w_next_state == ST_HALTED);
      r_fault <= w_fault_next;
      case (w_sel)
        SEL_SEQ:  r_pc <= w_pc_inc;
        SEL_TGT:  r_pc <= bus.Target;
        SEL_RET:  r_pc <= w_ras_top;
        SEL_RST:  r_pc <= RESET_PC;
        SEL_HOLD: r_pc <= r_pc;
        default:  r_pc <= r_pc;
      endcase
    end
  end

  assign bus.ProgCtr = r_pc;
  assign bus.Busy    = r_busy;
  assign bus.Done    = r_done;
  assign bus.Fault   = r_fault;

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pc_fetch_ctrl
// Self-checking bench: directed scenarios with literal expectations plus a
// randomized phase, all compared every cycle against a behavioural model
// (mode number, PC value, queue as return stack).
// -----------------------------------------------------------------------------
module tb_pc_fetch_ctrl;

  localparam int PC_W = 12;

  localparam logic [7:0] C_START = 8'h80;
  localparam logic [7:0] C_STALL = 8'h40;
  localparam logic [7:0] C_HALT  = 8'h20;
  localparam logic [7:0] C_JMP   = 8'h10;
  localparam logic [7:0] C_BREN  = 8'h08;
  localparam logic [7:0] C_BRC   = 8'h04;
  localparam logic [7:0] C_CALL  = 8'h02;
  localparam logic [7:0] C_RET   = 8'h01;

  logic Clk   = 1'b0;
  logic Reset = 1'b1;
  int   checks   = 0;
  int   failures = 0;
  bit   cmp_en   = 1'b0;

  pc_fetch_ctrl_if #(.PC_W(PC_W)) bus ();

  pc_fetch_ctrl #(
    .PC_W      (PC_W),
    .RAS_DEPTH (4),
    .RESET_PC  (12'd0)
  ) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus)
  );

  always #5 Clk = ~Clk;

  // ---------------- behavioural model ----------------
  // m_mode: 0 = idle, 1 = running, 2 = halted
  int         m_mode  = 0;
  int         m_pc    = 0;
  bit         m_fault = 1'b0;
  int         m_stack[$];

  task automatic model_reset();
    m_mode  = 0;
    m_pc    = 0;
    m_fault = 1'b0;
    m_stack.delete();
  endtask

  task automatic model_restart();
    m_mode  = 1;
    m_pc    = 0;
    m_fault = 1'b0;
    m_stack.delete();
  endtask

  task automatic model_edge();
    if (m_mode == 0) begin
      if (bus.Start) model_restart();
    end else if (m_mode == 2) begin
      if (bus.Start) model_restart();
    end else begin
      if (bus.Start) model_restart();
      else if (bus.Stall) begin end
      else if (bus.Halt) m_mode = 2;
      else if (bus.Ret) begin
        if (m_stack.size() == 0) begin
          m_fault = 1'b1;
          m_mode  = 2;
        end else begin
          m_pc = m_stack.pop_back();
        end
      end else if (bus.Call) begin
        if (m_stack.size() == 4) begin
          m_fault = 1'b1;
          m_mode  = 2;
        end else begin
          m_stack.push_back((m_pc + 1) % 4096);
          m_pc = int'(bus.Target);
        end
      end else if (bus.Jmp || (bus.BrEn && bus.BrCond)) m_pc = int'(bus.Target);
      else m_pc = (m_pc + 1) % 4096;
    end
  endtask

  always @(posedge Clk or negedge Reset) begin
    if (!Reset) model_reset();
    else model_edge();
  end

  // ---------------- checking ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Every-cycle comparison of all outputs against the model.
  always @(negedge Clk) begin
    if (cmp_en) begin
      chk("model_pc",    32'(bus.ProgCtr), 32'(m_pc));
      chk("model_busy",  32'(bus.Busy),    32'(m_mode == 1));
      chk("model_done",  32'(bus.Done),    32'(m_mode == 2));
      chk("model_fault", 32'(bus.Fault),   32'(m_fault));
    end
  end

  // Apply one cycle of controls; returns on the following falling edge.
  task automatic go(input logic [7:0] c, input logic [11:0] t);
    {bus.Start, bus.Stall, bus.Halt, bus.Jmp, bus.BrEn, bus.BrCond, bus.Call, bus.Ret} = c;
    bus.Target = t;
    @(negedge Clk);
  endtask

  initial begin
    logic [7:0] c;
    logic [11:0] t;
    {bus.Start, bus.Stall, bus.Halt, bus.Jmp, bus.BrEn, bus.BrCond, bus.Call, bus.Ret} = 8'h00;
    bus.Target = 12'd0;
    #1 Reset = 1'b0;
    @(negedge Clk);
    cmp_en = 1'b1;
    chk("reset_pc",    32'(bus.ProgCtr), 32'd0);
    chk("reset_busy",  32'(bus.Busy),    32'd0);
    chk("reset_done",  32'(bus.Done),    32'd0);
    chk("reset_fault", 32'(bus.Fault),   32'd0);
    Reset = 1'b1;

    // Idle ignores everything except Start.
    go(C_JMP | C_CALL, 12'd300);
    chk("idle_ignore_pc", 32'(bus.ProgCtr), 32'd0);

    // Sequential fetch after Start.
    go(C_START, 12'd0);
    chk("start_pc", 32'(bus.ProgCtr), 32'd0);
    chk("start_busy", 32'(bus.Busy), 32'd1);
    repeat (5) go(8'h00, 12'd0);
    chk("seq_pc5", 32'(bus.ProgCtr), 32'd5);
    repeat (2) go(8'h00, 12'd0);
    chk("seq_pc7", 32'(bus.ProgCtr), 32'd7);

    // Jump and branches.
    go(C_JMP, 12'd77);
    chk("jmp_77", 32'(bus.ProgCtr), 32'd77);
    go(C_BREN, 12'd500);
    chk("br_not_taken", 32'(bus.ProgCtr), 32'd78);
    go(C_BREN | C_BRC, 12'd10);
    chk("br_taken", 32'(bus.ProgCtr), 32'd10);
    go(C_BRC, 12'd900);
    chk("brcond_alone", 32'(bus.ProgCtr), 32'd11);

    // Nested call / return.
    go(C_JMP, 12'd20);
    go(C_CALL, 12'd83);
    chk("call1", 32'(bus.ProgCtr), 32'd83);
    go(C_CALL, 12'd101);
    chk("call2", 32'(bus.ProgCtr), 32'd101);
    go(C_RET, 12'd0);
    chk("ret1", 32'(bus.ProgCtr), 32'd84);
    go(C_RET, 12'd0);
    chk("ret2", 32'(bus.ProgCtr), 32'd21);
    chk("ret_nofault", 32'(bus.Fault), 32'd0);

    // Overflow on the fifth nested call.
    go(C_CALL, 12'd200);
    go(C_CALL, 12'd300);
    go(C_CALL, 12'd400);
    go(C_CALL, 12'd500);
    go(C_CALL, 12'd600);
    chk("ovf_fault", 32'(bus.Fault),   32'd1);
    chk("ovf_done",  32'(bus.Done),    32'd1);
    chk("ovf_pc",    32'(bus.ProgCtr), 32'd500);
    go(C_START, 12'd0);
    chk("restart_pc",    32'(bus.ProgCtr), 32'd0);
    chk("restart_fault", 32'(bus.Fault),   32'd0);
    chk("restart_busy",  32'(bus.Busy),    32'd1);
    go(C_RET, 12'd0);
    chk("udf_fault", 32'(bus.Fault), 32'd1);
    chk("udf_done",  32'(bus.Done),  32'd1);

    // Stall beats Jmp/Halt; then Halt freezes PC.
    go(C_START, 12'd0);
    repeat (3) go(8'h00, 12'd0);
    repeat (3) go(C_STALL | C_JMP | C_HALT, 12'd99);
    chk("stall_pc",   32'(bus.ProgCtr), 32'd3);
    chk("stall_busy", 32'(bus.Busy),    32'd1);
    go(C_HALT, 12'd0);
    chk("halt_done", 32'(bus.Done),    32'd1);
    chk("halt_pc",   32'(bus.ProgCtr), 32'd3);
    repeat (2) go(C_JMP, 12'd44);
    chk("halt_frozen", 32'(bus.ProgCtr), 32'd3);

    // PC wrap and return-address wrap.
    go(C_START, 12'd0);
    go(C_JMP, 12'd4095);
    go(8'h00, 12'd0);
    chk("wrap_seq", 32'(bus.ProgCtr), 32'd0);
    go(C_JMP, 12'd4095);
    go(C_CALL, 12'd5);
    go(C_RET, 12'd0);
    chk("wrap_ret", 32'(bus.ProgCtr), 32'd0);

    // Async reset mid-run with two stacked entries.
    go(C_CALL, 12'd10);
    go(C_CALL, 12'd50);
    chk("pre_rst_pc", 32'(bus.ProgCtr), 32'd50);
    #2 Reset = 1'b0;
    #1;
    chk("async_rst_pc",   32'(bus.ProgCtr), 32'd0);
    chk("async_rst_busy", 32'(bus.Busy),    32'd0);
    chk("async_rst_done", 32'(bus.Done),    32'd0);
    bus.Start = 1'b1;
    @(negedge Clk);
    chk("rst_hold_busy", 32'(bus.Busy), 32'd0);
    Reset = 1'b1;
    go(C_START, 12'd0);
    go(C_RET, 12'd0);
    chk("rst_cleared_ras", 32'(bus.Fault), 32'd1);

    // Randomized phase against the model.
    for (int i = 0; i < 3000; i++) begin
      c = 8'h00;
      if ($urandom_range(0, 39) == 0 || (m_mode != 1 && $urandom_range(0, 3) == 0)) c |= C_START;
      if ($urandom_range(0, 4) == 0)  c |= C_STALL;
      if ($urandom_range(0, 29) == 0) c |= C_HALT;
      if ($urandom_range(0, 5) == 0)  c |= C_RET;
      if ($urandom_range(0, 5) == 0)  c |= C_CALL;
      if ($urandom_range(0, 5) == 0)  c |= C_JMP;
      if ($urandom_range(0, 2) == 0)  c |= C_BREN;
      if ($urandom_range(0, 1) == 0)  c |= C_BRC;
      if ($urandom_range(0, 9) == 0) t = 12'hFFF;
      else t = 12'($urandom_range(0, 4095));
      go(c, t);
      if (i % 700 == 350) begin
        #2 Reset = 1'b0;
        @(negedge Clk);
        Reset = 1'b1;
      end
    end

    cmp_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
